// File: rtl/mem_arb_pkg.sv
// Purpose : shared constants for the two-port unified-memory arbiter.
// Latency : n/a (constants only).
// Backpr. : n/a.
// Contents: FSM state encodings, requester port IDs, wait-counter width.
package mem_arb_pkg;

  // FSM state encoding (2-bit, legacy-compatible constants)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Requester identities
  localparam logic PORT_CPU = 1'b0;  // multi-cycle MIPS core (IorD-muxed)
  localparam logic PORT_AUX = 1'b1;  // loader / DMA / debug

  // Wide enough for LAT-1 with LAT up to 15
  localparam int CNT_W = 4;

endpackage

// File: rtl/arb_pick.sv
// Purpose : combinational winner selection between the two memory requesters.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the caller only samples the result while idle.
// Ports   : req0/req1 requests, last_grant = most recent winner,
//           gnt_valid = someone is requesting, gnt_id = winning port.
// Config  : MEM_ARB_ROUND_ROBIN_EN defined -> alternate under contention;
//           undefined -> fixed priority, port 0 (CPU) always wins.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = PORT_AUX;
    if (req0 && req1) begin
      // Contention: hand the memory to whoever did not have it last time.
      gnt_id = ~last_grant;
    end else if (req0) begin
      gnt_id = PORT_CPU;
    end else begin
      gnt_id = PORT_AUX;
    end
  end
`else
  // Fixed priority ignores history; keep the input visibly consumed.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = req0 ? PORT_CPU : PORT_AUX;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose : shares the single unified I/D memory of the multi-cycle MIPS core
//           between the CPU (port 0) and a loader/DMA/debug port (port 1).
// Latency : req seen idle at cycle t -> memory strobes t+1..t+LAT, ack at t+LAT+1;
//           grants are spaced at least LAT+2 cycles apart.
// Backpr. : requesters hold req until their one-cycle ack; the loser simply
//           keeps waiting, nothing is queued inside the arbiter.
// Ports   : clk/rst (async active-high); pN_req/we/addr/wdata in, pN_ack/rdata out;
//           mem_read/mem_write/mem_addr/mem_wdata out, mem_rdata in;
//           busy (ACCESS or RESP), grant_id (owner of current/most recent transfer).
// Config  : MEM_ARB_ROUND_ROBIN_EN selects alternating grants under contention
//           (see arb_pick); default build is fixed CPU priority.
// Params  : AW address width, DW data width, LAT access cycles (legal 1..15).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  // port 0: CPU
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  // port 1: loader / DMA / debug
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  // memory side
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // status
  output logic          busy,
  output logic          grant_id
);

  // Counter preload: ACCESS runs cnt = LAT-1 down to 0, i.e. LAT cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    rdata0_q;
  logic [DW-1:0]    rdata1_q;
  logic             gid_q;
  logic             last_grant;

  logic             pick_vld;
  logic             pick_id;

  arb_pick u_pick (
    .req0       (p0_req),
    .req1       (p1_req),
    .last_grant (last_grant),
    .gnt_valid  (pick_vld),
    .gnt_id     (pick_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      gid_q      <= PORT_CPU;
      last_grant <= PORT_AUX;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            // Snapshot the winner; its live inputs are ignored from here on.
            state      <= ST_ACCESS;
            cnt        <= CNT_LOAD;
            gid_q      <= pick_id;
            last_grant <= pick_id;
            we_q       <= (pick_id == PORT_AUX) ? p1_we    : p0_we;
            addr_q     <= (pick_id == PORT_AUX) ? p1_addr  : p0_addr;
            wdata_q    <= (pick_id == PORT_AUX) ? p1_wdata : p0_wdata;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            // Last access cycle: memory data is valid now.
            state <= ST_RESP;
            if (!we_q) begin
              if (gid_q == PORT_AUX) rdata1_q <= mem_rdata;
              else                   rdata0_q <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          // Requests present now are only looked at once back in IDLE.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes and acks decode straight from state so an async reset kills
  // them in the same instant, without waiting for a clock.
  logic in_access;
  logic in_resp;

  assign in_access = (state == ST_ACCESS);
  assign in_resp   = (state == ST_RESP);

  assign mem_read  = in_access & ~we_q;
  assign mem_write = in_access &  we_q;
  assign mem_addr  = addr_q;   // holds last transfer's values outside ACCESS
  assign mem_wdata = wdata_q;

  assign p0_ack    = in_resp & (gid_q == PORT_CPU);
  assign p1_ack    = in_resp & (gid_q == PORT_AUX);
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

  assign busy      = in_access | in_resp;
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT A (LAT=2) ----------------
  logic          p0_req, p0_we, p0_ack;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_ack;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          mem_read, mem_write, busy, grant_id;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // ---------------- DUT B (LAT=1) ----------------
  logic          b_p0_req, b_p0_we, b_p0_ack;
  logic [AW-1:0] b_p0_addr;
  logic [DW-1:0] b_p0_wdata, b_p0_rdata;
  logic          b_p1_req, b_p1_we, b_p1_ack;
  logic [AW-1:0] b_p1_addr;
  logic [DW-1:0] b_p1_wdata, b_p1_rdata;
  logic          b_mem_read, b_mem_write, b_busy, b_grant_id;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT_A)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst),
    .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .grant_id(b_grant_id)
  );

  // Memory model: fixed contents per address
  function automatic logic [31:0] memfn(input logic [31:0] a);
    case (a)
      32'h40:  memfn = 32'hDEADBEEF;
      32'h44:  memfn = 32'hCAFEF00D;
      32'h48:  memfn = 32'h13579BDF;
      32'h4C:  memfn = 32'h2468ACE0;
      32'h100: memfn = 32'h0F0F1234;
      default: memfn = 32'hBAD00000 | a;
    endcase
  endfunction

  assign mem_rdata   = memfn(mem_addr);
  assign b_mem_rdata = memfn(b_mem_addr);

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t sb1[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor A ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_read || mem_write) begin
        if (sb.size() == 0) begin
          chk("strobe_without_txn", {mem_read, mem_write}, 0);
        end else begin
          chk("mem_rd_wr_excl", mem_read & mem_write, 0);
          chk("mem_read_dir", mem_read, !sb[0].we);
          chk("mem_addr", mem_addr, sb[0].addr);
          if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
        end
        strobe_cnt++;
      end
      if (p0_ack || p1_ack) begin
        chk("ack_onehot", p0_ack & p1_ack, 0);
        if (sb.size() == 0) begin
          chk("unexpected_ack", {p1_ack, p0_ack}, 0);
        end else begin
          e = sb.pop_front();
          chk("ack_port", p1_ack, e.port);
          chk("ack_cycle", cyc, e.cyc);
          chk("rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
          chk("strobe_cycles", strobe_cnt, LAT_A);
          strobe_cnt = 0;
        end
      end
    end
  end

  // ---------------- monitor B ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (b_mem_read || b_mem_write) begin
        if (sb1.size() == 0) chk("b_strobe_without_txn", {b_mem_read, b_mem_write}, 0);
        else                 chk("b_mem_addr", {b_mem_write, b_mem_addr}, {1'b0, sb1[0].addr});
      end
      if (b_p0_ack || b_p1_ack) begin
        if (sb1.size() == 0) begin
          chk("b_unexpected_ack", {b_p1_ack, b_p0_ack}, 0);
        end else begin
          e = sb1.pop_front();
          chk("b_ack_port", b_p1_ack, e.port);
          chk("b_ack_cycle", cyc, e.cyc);
          chk("b_rdata", b_p0_rdata, e.rdata);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Call at a negedge with DUT A idle.
  task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rexp);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rexp;
    e.cyc  = cyc + LAT_A + 1;
    sb.push_back(e);
    if (port) begin
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end
  endtask

  task automatic wait_acks(input int n);
    int got   = 0;
    int guard = 0;
    while (got < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if (p0_ack || p1_ack) got++;
    end
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL ack_timeout: got %0d acks expected %0d", got, n);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    exp_t e;
    int got;
    int guard;
    logic [31:0] sweep_addr [4];

    rst = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    b_p0_req = 0; b_p0_we = 0; b_p0_addr = 0; b_p0_wdata = 0;
    b_p1_req = 0; b_p1_we = 0; b_p1_addr = 0; b_p1_wdata = 0;

    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_acks",      {p0_ack, p1_ack}, 0);
    chk("rst_strobes",   {mem_read, mem_write}, 0);
    chk("rst_mem_addr",  mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata",     {p0_rdata, p1_rdata}, 0);
    chk("rst_busy_gid",  {busy, grant_id}, 0);

    rst = 1'b0;
    @(negedge clk);

    // Single read by CPU
    issue(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
    wait_acks(1);
    repeat (2) @(negedge clk);

    // Write by aux port; its rdata stays at the reset value
    issue(1'b1, 1'b1, 32'h80, 32'h1234, 32'h0);
    wait_acks(1);
    repeat (2) @(negedge clk);

    // Contention: both held high for 4 transfers (last_grant is now AUX)
    k = cyc;
    for (int i = 0; i < 4; i++) begin
      e.port  = RR ? i[0] : 1'b0;
      e.we    = 1'b0;
      e.addr  = e.port ? 32'h48 : 32'h40;
      e.wdata = 32'h0;
      e.rdata = e.port ? 32'h13579BDF : 32'hDEADBEEF;
      e.cyc   = k + LAT_A + 1 + i * (LAT_A + 2);
      sb.push_back(e);
    end
    p0_we = 0; p0_addr = 32'h40; p0_req = 1;
    p1_we = 0; p1_addr = 32'h48; p1_req = 1;
    wait_acks(4);
    repeat (2) @(negedge clk);

    // Input churn after grant
    issue(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
    @(negedge clk);
    p0_addr = 32'h44;
    wait_acks(1);
    repeat (2) @(negedge clk);

    // Reset in the 2nd ACCESS cycle
    issue(1'b1, 1'b0, 32'h48, 32'h0, 32'h13579BDF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    p1_req = 1'b0;
    #1;
    chk("rst_mid_strobes", {mem_read, mem_write}, 0);
    chk("rst_mid_acks",    {p0_ack, p1_ack}, 0);
    chk("rst_mid_busy",    busy, 0);
    sb.delete();
    strobe_cnt = 0;
    repeat (2) @(negedge clk);
    chk("rst_mid_gid", grant_id, 0);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b1, 1'b0, 32'h100, 32'h0, 32'h0F0F1234);
    wait_acks(1);
    repeat (2) @(negedge clk);

    // LAT=1 back-to-back CPU reads on DUT B
    sweep_addr[0] = 32'h40; sweep_addr[1] = 32'h44;
    sweep_addr[2] = 32'h48; sweep_addr[3] = 32'h4C;
    k = cyc;
    for (int i = 0; i < 4; i++) begin
      e.port  = 1'b0;
      e.we    = 1'b0;
      e.addr  = sweep_addr[i];
      e.wdata = 32'h0;
      e.cyc   = k + LAT_B + 1 + i * (LAT_B + 2);
      e.rdata = memfn(sweep_addr[i]);
      sb1.push_back(e);
    end
    b_p0_addr = sweep_addr[0];
    b_p0_req  = 1'b1;
    got = 0;
    guard = 0;
    while (got < 4 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (b_p0_ack) begin
        got++;
        if (got < 4) b_p0_addr = sweep_addr[got];
      end
    end
    b_p0_req = 1'b0;
    checks++;
    if (got < 4) begin
      errors++;
      $display("FAIL b_ack_timeout: got %0d acks expected 4", got);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size() + sb1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
